// File: rtl/approx_div_pkg.sv
// Shared types and the approximate-cell selector for the sequential divider.
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A cell is approximate in the lower-left triangle of the (step, column) grid.
  function automatic logic is_approx(input int i, input int j, input int k, input logic en);
    return en && ((i + j) < k);
  endfunction

endpackage

// File: rtl/approx_div_step.sv
// One restoring-division row: W-column borrow chain of T[W-1:0] - d.
module approx_div_step
  import approx_div_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = 6,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W:0]    t_i,
  input  logic [W-1:0]  d_i,
  input  logic [IW-1:0] idx_i,
  input  logic          en_i,
  output logic          qbit_o,
  output logic [W-1:0]  r_o
);

  logic [W:0]   bchain;
  logic [W-1:0] diff;
  logic [W-1:0] ap;

  assign bchain[0] = 1'b0;

  for (genvar j = 0; j < W; j++) begin : g_col
    logic x, y;
    assign x        = t_i[j];
    assign y        = d_i[j];
    assign ap[j]    = is_approx(int'(idx_i), j, K, en_i);
    assign diff[j]  = ap[j] ? x : (x ^ y ^ bchain[j]);
    assign bchain[j+1] = ap[j] ? ~bchain[j]
                               : ((~x & y) | (~(x ^ y) & bchain[j]));
  end

  assign qbit_o = t_i[W] | ~bchain[W];
  assign r_o    = qbit_o ? diff : t_i[W-1:0];

endmodule

// File: rtl/approx_seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, optional approximate cells.
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dz
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_e         state_q, state_d;
  logic [2*W-1:0] n_q;
  logic [W-1:0]   d_q;
  logic           en_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [IW-1:0]  i_q;
  logic           fin_q;
  logic [W-1:0]   q_q, r_q;
  logic           dz_q;

  logic [W:0]     t;
  logic           qbit;
  logic [W-1:0]   rnext;

  assign t = {rem_q, n_q[i_q]};

  approx_div_step #(.W(W), .K(K), .IW(IW)) u_step (
    .t_i    (t),
    .d_i    (d_q),
    .idx_i  (i_q),
    .en_i   (en_q),
    .qbit_o (qbit),
    .r_o    (rnext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (fin_q)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // After the last bit, one extra RUN cycle commits the result so q/r/dz come from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q   <= '0;
      d_q   <= '0;
      en_q  <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      i_q   <= '0;
      fin_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          n_q   <= n;
          d_q   <= d;
          en_q  <= approx_en;
          rem_q <= n[2*W-1:W];
          quo_q <= '0;
          i_q   <= IW'(W - 1);
          fin_q <= 1'b0;
        end
        RUN: if (!fin_q) begin
          quo_q[i_q] <= qbit;
          rem_q      <= rnext;
          if (i_q == '0) fin_q <= 1'b1;
          else           i_q   <= i_q - 1'b1;
        end else begin
          q_q   <= quo_q;
          r_q   <= rem_q;
          dz_q  <= (d_q == '0);
          fin_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign q  = q_q;
  assign r  = r_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_approx_seq_divider.sv
// Directed and randomized checks of approx_seq_divider against a bench-side model.
module tb_approx_seq_divider;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, out_ready, approx_en;
  logic [2*W-1:0] n;
  logic [W-1:0]   d;
  logic           in_ready, out_valid, dz;
  logic [W-1:0]   q, r;
  logic           in_ready0, out_valid0, dz0;
  logic [W-1:0]   q0, r0;

  int errors = 0;
  int checks = 0;

  approx_seq_divider #(.W(W), .K(6)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .d(d), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r), .dz(dz)
  );

  approx_seq_divider #(.W(W), .K(0)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .n(n), .d(d), .approx_en(approx_en), .out_valid(out_valid0),
    .out_ready(out_ready), .q(q0), .r(r0), .dz(dz0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: long division driven by the cell rules, each bit handled as plain integers.
  task automatic model(input logic [2*W-1:0] nn, input logic [W-1:0] dd, input bit en,
                       input int k, output logic [W-1:0] qq, output logic [W-1:0] rr);
    int rem, tv, bin, x, y, dif, qb;
    rem = int'(nn[2*W-1:W]);
    qq  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      tv  = rem * 2 + int'(nn[i]);
      bin = 0;
      dif = 0;
      for (int j = 0; j < W; j++) begin
        x = (tv >> j) & 1;
        y = (int'(dd) >> j) & 1;
        if (en && (i + j) < k) begin
          dif = dif | (x << j);
          bin = 1 - bin;
        end else begin
          dif = dif | (((x + y + bin) & 1) << j);
          bin = ((x == 0 && y == 1) || (x == y && bin == 1)) ? 1 : 0;
        end
      end
      qb = ((tv >> W) & 1) | (1 - bin);
      qq[i] = qb[0];
      rem = qb ? dif : (tv % (1 << W));
    end
    rr = rem[W-1:0];
  endtask

  logic [W-1:0] eq, er, eq0, er0;

  task automatic run_op(input string tag, input logic [2*W-1:0] nn, input logic [W-1:0] dd,
                        input bit en);
    int lat;
    model(nn, dd, en, 6, eq, er);
    model(nn, dd, en, 0, eq0, er0);
    n = nn; d = dd; approx_en = en; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 16'($urandom); d = 8'($urandom); approx_en = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, W + 1);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".r"}, r, er);
    chk({tag, ".dz"}, dz, (dd == 0));
    chk({tag, ".k0"}, {out_valid0, q0, r0}, {1'b1, eq0, er0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".rel"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [W-1:0] hq, hr;
    logic [2*W-1:0] rn;
    logic [W-1:0] rd;
    bit ren;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; approx_en = 1'b0; n = '0; d = '0;
    #23;
    chk("reset", {in_ready, out_valid, q, r, dz}, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("exact", 16'd1000, 8'd7, 1'b0);
    chk("exact.q_const", {q, r}, {8'd142, 8'd6});

    run_op("approx", 16'h0003, 8'd1, 1'b1);
    chk("approx.q_const", {q, r}, {8'h15, 8'd3});
    chk("approx.k0_const", {q0, r0}, {8'd3, 8'd0});

    run_op("approx_off", 16'h0003, 8'd1, 1'b0);
    chk("approx_off.q_const", {q, r}, {8'd3, 8'd0});

    run_op("benign", 16'h4000, 8'h80, 1'b1);
    chk("benign.q_const", {q, r}, {8'd128, 8'd0});

    run_op("divzero", 16'h12AB, 8'h00, 1'b0);
    chk("divzero.q_const", {q, r, dz}, {8'hFF, 8'hAB, 1'b1});

    // Back-pressure: hold the result while a competing request is offered.
    n = 16'd5000; d = 8'd61; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
    chk("bp.valid", out_valid, 1'b1);
    chk("bp.result", {q, r}, {8'(5000 / 61), 8'(5000 % 61)});
    hq = q; hr = r;
    n = 16'h0101; d = 8'h02; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp.hold", {out_valid, in_ready, q, r}, {1'b1, 1'b0, hq, hr});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.release", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    chk("bp.idle", {out_valid, in_ready}, 2'b01);

    // Reset while the step counter is at 4.
    n = 16'd999; d = 8'd10; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst", {in_ready, out_valid, q, r, dz}, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.idle", {in_ready, out_valid}, 2'b10);
    run_op("after_rst", 16'd999, 8'd10, 1'b0);
    chk("after_rst.arith", {q, r}, {8'd99, 8'd9});

    for (int k = 0; k < 24; k++) begin
      rn = 16'($urandom); rd = 8'($urandom); ren = 1'($urandom);
      run_op($sformatf("rand%0d", k), rn, rd, ren);
      if (!ren && rd != 0 && rn[2*W-1:W] < rd)
        chk($sformatf("rand%0d.arith", k), {q, r}, {8'(rn / rd), 8'(rn % rd)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
